// File: rtl/pipe_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module   : pipe_hazard_ctrl
// Purpose  : Y86-64 pipeline hazard control with memory wait, halt FSM,
//            memory watchdog and saturating stall/bubble counters.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int ICODE_W     = 4,
    parameter int REG_W       = 4,
    parameter int STAT_W      = 2,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ICODE_W-1:0] D_icode,
    input  logic [ICODE_W-1:0] E_icode,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic [REG_W-1:0]   E_dstM,
    input  logic [REG_W-1:0]   d_srcA,
    input  logic [REG_W-1:0]   d_srcB,
    input  logic               e_cnd,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [STAT_W-1:0]  W_stat,
    input  logic               m_mem_req,
    input  logic               m_ready,
    output logic               F_stall,
    output logic               D_stall,
    output logic               E_stall,
    output logic               M_stall,
    output logic               W_stall,
    output logic               D_bubble,
    output logic               E_bubble,
    output logic               M_bubble,
    output logic               W_bubble,
    output logic               set_cc,
    output logic               halted,
    output logic               mem_timeout,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [ICODE_W-1:0] C_IMRMOVQ = ICODE_W'(4'h5);
    localparam logic [ICODE_W-1:0] C_IOPQ    = ICODE_W'(4'h6);
    localparam logic [ICODE_W-1:0] C_IJXX    = ICODE_W'(4'h7);
    localparam logic [ICODE_W-1:0] C_IRET    = ICODE_W'(4'h9);
    localparam logic [ICODE_W-1:0] C_IPOPQ   = ICODE_W'(4'hB);
    localparam logic [REG_W-1:0]   C_RNONE   = '1;
    localparam logic [STAT_W-1:0]  C_AOK     = '0;
    localparam logic [WAIT_W-1:0]  C_TIMEOUT = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALTED   = 2'd2
    } state_t;

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_halted;
    logic               r_mem_timeout;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_bubble_cnt;

    logic w_ret, w_lu, w_mis, w_mw, w_w_exc, w_m_exc, w_is_halted;

    assign w_ret = (D_icode == C_IRET) || (E_icode == C_IRET) || (M_icode == C_IRET);
    assign w_lu  = ((E_icode == C_IMRMOVQ) || (E_icode == C_IPOPQ)) && (E_dstM != C_RNONE)
                   && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign w_mis = (E_icode == C_IJXX) && !e_cnd;
    assign w_mw  = m_mem_req && !m_ready;

    assign w_w_exc     = (W_stat != C_AOK);
    assign w_m_exc     = (m_stat != C_AOK);
    assign w_is_halted = (r_state == S_HALTED);

    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        E_stall  = 1'b0;
        M_stall  = 1'b0;
        W_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_bubble = 1'b0;
        set_cc   = 1'b0;
        if (rst_n) begin
            if (w_is_halted) begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                E_stall = 1'b1;
                M_stall = 1'b1;
                W_stall = 1'b1;
            end else if (w_w_exc) begin
                W_stall  = 1'b1;
                M_bubble = 1'b1;
            end else if (!w_m_exc && w_mw) begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                E_stall  = 1'b1;
                M_stall  = 1'b1;
                W_bubble = 1'b1;
            end else begin
                // A memory-stage exception squashes M but front-end hazards still apply
                M_bubble = w_m_exc;
                F_stall  = w_lu | w_ret;
                D_stall  = w_lu;
                D_bubble = w_mis | (w_ret & !w_lu);
                E_bubble = w_mis | w_lu;
            end
            set_cc = (E_icode == C_IOPQ) && !w_m_exc && !w_w_exc && !w_mw && !w_is_halted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_wait_cnt    <= '0;
            r_halted      <= 1'b0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_w_exc) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end else if (w_mw) begin
                        r_state    <= S_MEM_WAIT;
                        r_wait_cnt <= WAIT_W'(1);
                    end
                end
                S_MEM_WAIT: begin
                    if (w_w_exc) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end else if (!w_mw) begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= '0;
                    end else if ((MEM_TIMEOUT != 0) && (r_wait_cnt == C_TIMEOUT)) begin
                        r_state       <= S_HALTED;
                        r_halted      <= 1'b1;
                        r_mem_timeout <= 1'b1;
                    end else if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    r_state  <= S_HALTED;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (F_stall && !w_is_halted && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if ((D_bubble || E_bubble) && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign halted      = r_halted;
    assign mem_timeout = r_mem_timeout;
    assign stall_cnt   = r_stall_cnt;
    assign bubble_cnt  = r_bubble_cnt;

endmodule

`default_nettype wire
